// File: rtl/data_fill_sequencer_if.sv
// Refill-line handshake and blockram write bus of the L1 data fill sequencer.
// master: refill path / controller side; slave: the sequencer.
// Optional macro FILL_CRIT_FIRST_EN adds crit_written.
//
// Signals:
//   fill_valid/fill_ready  line handshake (ready driven by sequencer)
//   fill_data/index/way    line payload and destination
//   fill_crit              critical quarter (critical-first builds only)
//   wr_en/wr_addr/wr_data  one 128-bit quarter write per cycle
//   fill_done              last beat of a line
//   busy/busy_index        set currently being filled
interface data_fill_sequencer_if #(
    parameter int INDEX_W = 8,
    parameter int LINE_W  = 512,
    parameter int BEAT_W  = 128
);
    logic               fill_valid;
    logic               fill_ready;
    logic [LINE_W-1:0]  fill_data;
    logic [INDEX_W-1:0] fill_index;
    logic [1:0]         fill_way;
    logic [1:0]         fill_crit;
    logic               wr_en;
    logic [INDEX_W+3:0] wr_addr;
    logic [BEAT_W-1:0]  wr_data;
    logic               fill_done;
    logic               busy;
    logic [INDEX_W-1:0] busy_index;
`ifdef FILL_CRIT_FIRST_EN
    logic               crit_written;
`endif

    modport master (
`ifdef FILL_CRIT_FIRST_EN
        input  crit_written,
`endif
        output fill_valid,
        output fill_data,
        output fill_index,
        output fill_way,
        output fill_crit,
        input  fill_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  fill_done,
        input  busy,
        input  busy_index
    );

    modport slave (
`ifdef FILL_CRIT_FIRST_EN
        output crit_written,
`endif
        input  fill_valid,
        input  fill_data,
        input  fill_index,
        input  fill_way,
        input  fill_crit,
        output fill_ready,
        output wr_en,
        output wr_addr,
        output wr_data,
        output fill_done,
        output busy,
        output busy_index
    );
endinterface

// File: rtl/data_fill_sequencer.sv
// L1 data blockram fill sequencer: takes one 512-bit refill line per
// handshake and writes it as four 128-bit quarters, one per clk1 cycle.
//
// Ports:
//   clk1  clock
//   rst   asynchronous active-high reset
//   bus   data_fill_sequencer_if.slave (fill handshake + blockram writes)
//
// Optional macro FILL_CRIT_FIRST_EN: write order starts at fill_crit and
// crit_written flags the critical-quarter beat.
module data_fill_sequencer #(
    parameter int INDEX_W = 8,
    parameter int LINE_W  = 512,
    parameter int BEAT_W  = 128
) (
    input  logic                 clk1,
    input  logic                 rst,
    data_fill_sequencer_if.slave bus
);
    localparam int OFS_W = $clog2(BEAT_W);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [1:0]         cnt;
    logic [LINE_W-1:0]  line_r;
    logic [INDEX_W-1:0] idx_r;
    logic [1:0]         way_r;
    logic [1:0]         q;
    logic [OFS_W+1:0]   base;
    logic               last;
    logic               ready;
    logic               accept;
    logic               wr_en;
    logic               busy;
    logic               done;

    assign last   = (state == WRITE) && (cnt == 2'd3);
    // Ready depends on state only; rst forces it low while held.
    assign ready  = !rst && ((state == IDLE) || last);
    assign accept = bus.fill_valid && ready;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                wr_en = 1'b1;
                busy  = 1'b1;
                done  = last;
                // A line offered on the last beat keeps us in WRITE
                // so its first quarter follows with no bubble.
                if (last && !accept) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // cnt is not advanced past 3 on the way to IDLE, so address and
    // data keep showing the last write while idle.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            cnt    <= 2'd0;
            line_r <= '0;
            idx_r  <= '0;
            way_r  <= 2'd0;
        end else if (accept) begin
            cnt    <= 2'd0;
            line_r <= bus.fill_data;
            idx_r  <= bus.fill_index;
            way_r  <= bus.fill_way;
        end else if ((state == WRITE) && !last) begin
            cnt    <= cnt + 2'd1;
        end
    end

`ifdef FILL_CRIT_FIRST_EN
    logic [1:0] crit_r;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            crit_r <= 2'd0;
        end else if (accept) begin
            crit_r <= bus.fill_crit;
        end
    end

    // 2-bit add wraps the order around the line.
    assign q = crit_r + cnt;
    assign bus.crit_written = (state == WRITE) && (cnt == 2'd0);
`else
    logic unused_crit;

    assign unused_crit = ^bus.fill_crit;
    assign q = cnt;
`endif

    assign base = {q, {OFS_W{1'b0}}};

    assign bus.fill_ready = ready;
    assign bus.wr_en      = wr_en;
    assign bus.wr_addr    = {idx_r, q, way_r};
    assign bus.wr_data    = line_r[base +: BEAT_W];
    assign bus.fill_done  = done;
    assign bus.busy       = busy;
    assign bus.busy_index = idx_r;
endmodule

// File: tb/tb_data_fill_sequencer.sv
// Self-checking bench for data_fill_sequencer.
// Expected quarter writes are queued on accept and popped per wr_en.
module tb_data_fill_sequencer;
    localparam int INDEX_W = 8;
    localparam int LINE_W  = 512;
    localparam int BEAT_W  = 128;
`ifdef FILL_CRIT_FIRST_EN
    localparam bit CRIT_FIRST = 1'b1;
`else
    localparam bit CRIT_FIRST = 1'b0;
`endif

    typedef struct {
        logic [INDEX_W+3:0] addr;
        logic [BEAT_W-1:0]  data;
        logic               done;
    } beat_t;

    logic  clk1 = 1'b0;
    logic  rst  = 1'b1;
    int    total = 0;
    int    bad   = 0;
    beat_t sbq[$];
    beat_t mon_e;

    data_fill_sequencer_if #(
        .INDEX_W(INDEX_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)
    ) bus ();

    data_fill_sequencer #(
        .INDEX_W(INDEX_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)
    ) dut (
        .clk1(clk1),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk1 = ~clk1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [LINE_W-1:0] mk_line(
        input logic [BEAT_W-1:0] q0, input logic [BEAT_W-1:0] q1,
        input logic [BEAT_W-1:0] q2, input logic [BEAT_W-1:0] q3);
        return {q3, q2, q1, q0};
    endfunction

    function automatic logic [BEAT_W-1:0] rnd_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push_line(input logic [LINE_W-1:0] line,
                             input logic [INDEX_W-1:0] idx,
                             input logic [1:0] way, input logic [1:0] crit);
        for (int k = 0; k < 4; k++) begin
            beat_t b;
            logic [1:0] qq;
            qq = 2'(k) + (CRIT_FIRST ? crit : 2'd0);
            b.addr = {idx, qq, way};
            b.data = line[int'(qq)*BEAT_W +: BEAT_W];
            b.done = (k == 3);
            sbq.push_back(b);
        end
    endtask

    task automatic offer(input logic [LINE_W-1:0] line,
                         input logic [INDEX_W-1:0] idx,
                         input logic [1:0] way, input logic [1:0] crit);
        bus.fill_valid = 1'b1;
        bus.fill_data  = line;
        bus.fill_index = idx;
        bus.fill_way   = way;
        bus.fill_crit  = crit;
    endtask

    // Scoreboard monitor: every write is popped and compared in order.
    always @(negedge clk1) begin
        if (!rst) begin
            if (bus.wr_en === 1'b1) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write addr=%h exp=no write", bus.wr_addr);
                end else begin
                    mon_e = sbq.pop_front();
                    if (bus.wr_addr !== mon_e.addr || bus.wr_data !== mon_e.data
                        || bus.fill_done !== mon_e.done) begin
                        bad++;
                        $display("FAIL beat got=%h/%h/%b exp=%h/%h/%b",
                                 bus.wr_addr, bus.wr_data, bus.fill_done,
                                 mon_e.addr, mon_e.data, mon_e.done);
                    end
                end
            end else begin
                total++;
                if (bus.fill_done !== 1'b0) begin
                    bad++;
                    $display("FAIL done_no_write got=%b exp=0", bus.fill_done);
                end
            end
        end
    end

    task automatic test_reset();
        bus.fill_valid = 1'b0;
        bus.fill_data  = '0;
        bus.fill_index = '0;
        bus.fill_way   = 2'd0;
        bus.fill_crit  = 2'd0;
        rst = 1'b1;
        #2;
        total++; if (bus.fill_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", bus.fill_ready); end
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b exp=0", bus.wr_en); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        total++; if (bus.fill_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.fill_done); end
        total++; if (bus.wr_addr !== '0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bus.wr_addr); end
        total++; if (bus.wr_data !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", bus.wr_data); end
        total++; if (bus.busy_index !== '0) begin bad++; $display("FAIL rst_bidx got=%h exp=0", bus.busy_index); end
`ifdef FILL_CRIT_FIRST_EN
        total++; if (bus.crit_written !== 1'b0) begin bad++; $display("FAIL rst_crit got=%b exp=0", bus.crit_written); end
`endif
        repeat (2) @(negedge clk1);
        rst = 1'b0;
        #1;
        total++; if (bus.fill_ready !== 1'b1) begin bad++; $display("FAIL rel_ready got=%b exp=1", bus.fill_ready); end
    endtask

    task automatic test_single();
        @(posedge clk1); #1;
        offer(mk_line(128'hA, 128'hB, 128'hC, 128'hD), 8'h3C, 2'd2, 2'd0);
        push_line(bus.fill_data, 8'h3C, 2'd2, 2'd0);
        @(negedge clk1);
        total++; if (bus.fill_ready !== 1'b1) begin bad++; $display("FAIL single_ready0 got=%b exp=1", bus.fill_ready); end
        @(posedge clk1); #1;
        bus.fill_valid = 1'b0;
        bus.fill_data  = '0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk1);
            total++; if (bus.wr_en !== 1'b1 || bus.busy !== 1'b1) begin bad++; $display("FAIL single_wr k=%0d got=%b%b exp=11", k, bus.wr_en, bus.busy); end
            total++; if (bus.fill_ready !== (k == 4)) begin bad++; $display("FAIL single_ready k=%0d got=%b exp=%b", k, bus.fill_ready, k == 4); end
            total++; if (bus.busy_index !== 8'h3C) begin bad++; $display("FAIL single_bidx got=%h exp=3c", bus.busy_index); end
        end
        @(negedge clk1);
        total++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b%b exp=00", bus.wr_en, bus.busy); end
        total++; if (bus.wr_addr !== 12'h3CE) begin bad++; $display("FAIL single_hold got=%h exp=3ce", bus.wr_addr); end
        total++; if (sbq.size() != 0) begin bad++; $display("FAIL single_left got=%0d exp=0", sbq.size()); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk1); #1;
        offer(mk_line(rnd_beat(), rnd_beat(), rnd_beat(), rnd_beat()), 8'h01, 2'd0, 2'd0);
        push_line(bus.fill_data, 8'h01, 2'd0, 2'd0);
        @(negedge clk1);
        total++; if (bus.fill_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready0 got=%b exp=1", bus.fill_ready); end
        @(posedge clk1); #1;
        offer(mk_line(rnd_beat(), rnd_beat(), rnd_beat(), rnd_beat()), 8'h02, 2'd3, 2'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk1);
            total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL b2b_gap k=%0d got=%b exp=1", k, bus.wr_en); end
            total++; if (bus.busy_index !== ((k <= 4) ? 8'h01 : 8'h02)) begin bad++; $display("FAIL b2b_bidx k=%0d got=%h exp=%h", k, bus.busy_index, (k <= 4) ? 8'h01 : 8'h02); end
            total++; if (bus.fill_done !== (k == 4 || k == 8)) begin bad++; $display("FAIL b2b_done k=%0d got=%b exp=%b", k, bus.fill_done, k == 4 || k == 8); end
            total++; if (bus.fill_ready !== (k == 4 || k == 8)) begin bad++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, bus.fill_ready, k == 4 || k == 8); end
            if (k == 4) begin
                push_line(bus.fill_data, 8'h02, 2'd3, 2'd0);
                @(posedge clk1); #1;
                bus.fill_valid = 1'b0;
            end
        end
        @(negedge clk1);
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", bus.wr_en); end
        total++; if (sbq.size() != 0) begin bad++; $display("FAIL b2b_left got=%0d exp=0", sbq.size()); end
    endtask

    task automatic test_busy_offer();
        @(posedge clk1); #1;
        offer(mk_line(rnd_beat(), rnd_beat(), rnd_beat(), rnd_beat()), 8'h55, 2'd1, 2'd0);
        push_line(bus.fill_data, 8'h55, 2'd1, 2'd0);
        @(posedge clk1); #1;
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) begin
                offer(mk_line(rnd_beat(), rnd_beat(), rnd_beat(), rnd_beat()), 8'(k), 2'(k), 2'd0);
            end else begin
                offer(mk_line(rnd_beat(), rnd_beat(), rnd_beat(), rnd_beat()), 8'hA7, 2'd2, 2'd0);
            end
            @(negedge clk1);
            total++; if (bus.fill_ready !== (k == 4)) begin bad++; $display("FAIL busy_ready k=%0d got=%b exp=%b", k, bus.fill_ready, k == 4); end
            total++; if (bus.busy_index !== 8'h55) begin bad++; $display("FAIL busy_bidx k=%0d got=%h exp=55", k, bus.busy_index); end
            if (k == 4) begin
                push_line(bus.fill_data, 8'hA7, 2'd2, 2'd0);
            end
            @(posedge clk1); #1;
        end
        bus.fill_valid = 1'b0;
        for (int k = 5; k <= 8; k++) begin
            @(negedge clk1);
            total++; if (bus.busy_index !== 8'hA7) begin bad++; $display("FAIL busy_bidx2 k=%0d got=%h exp=a7", k, bus.busy_index); end
        end
        @(negedge clk1);
        total++; if (sbq.size() != 0) begin bad++; $display("FAIL busy_left got=%0d exp=0", sbq.size()); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk1); #1;
        offer(mk_line(rnd_beat(), rnd_beat(), rnd_beat(), rnd_beat()), 8'h21, 2'd2, 2'd0);
        push_line(bus.fill_data, 8'h21, 2'd2, 2'd0);
        @(posedge clk1); #1;
        bus.fill_valid = 1'b0;
        repeat (2) @(negedge clk1);
        total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL mid_beat1 got=%b exp=1", bus.wr_en); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL mid_wr_en got=%b exp=0", bus.wr_en); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
        total++; if (bus.fill_done !== 1'b0) begin bad++; $display("FAIL mid_done got=%b exp=0", bus.fill_done); end
        total++; if (bus.fill_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got=%b exp=0", bus.fill_ready); end
        sbq.delete();
        @(negedge clk1);
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL mid_hold got=%b exp=0", bus.wr_en); end
        rst = 1'b0;
        #1;
        total++; if (bus.fill_ready !== 1'b1) begin bad++; $display("FAIL mid_rel got=%b exp=1", bus.fill_ready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk1);
            total++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL mid_after k=%0d got=%b%b exp=00", k, bus.wr_en, bus.busy); end
        end
    endtask

    task automatic test_wrap();
        @(posedge clk1); #1;
        offer(mk_line(rnd_beat(), rnd_beat(), rnd_beat(), rnd_beat()), 8'hFF, 2'd3, 2'd0);
        push_line(bus.fill_data, 8'hFF, 2'd3, 2'd0);
        @(posedge clk1); #1;
        bus.fill_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [11:0] ea;
            ea = 12'hFF3 + 12'(4 * k);
            @(negedge clk1);
            total++; if (bus.wr_addr !== ea) begin bad++; $display("FAIL wrap_addr k=%0d got=%h exp=%h", k, bus.wr_addr, ea); end
        end
        @(negedge clk1);
        total++; if (sbq.size() != 0) begin bad++; $display("FAIL wrap_left got=%0d exp=0", sbq.size()); end
    endtask

    task automatic test_crit_order();
        logic [11:0] ea [4];
`ifdef FILL_CRIT_FIRST_EN
        ea = '{12'h10D, 12'h101, 12'h105, 12'h109};
`else
        ea = '{12'h101, 12'h105, 12'h109, 12'h10D};
`endif
        @(posedge clk1); #1;
        offer(mk_line(rnd_beat(), rnd_beat(), rnd_beat(), rnd_beat()), 8'h10, 2'd1, 2'd3);
        push_line(bus.fill_data, 8'h10, 2'd1, 2'd3);
        @(posedge clk1); #1;
        bus.fill_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk1);
            total++; if (bus.wr_addr !== ea[k]) begin bad++; $display("FAIL crit_addr k=%0d got=%h exp=%h", k, bus.wr_addr, ea[k]); end
`ifdef FILL_CRIT_FIRST_EN
            total++; if (bus.crit_written !== (k == 0)) begin bad++; $display("FAIL crit_flag k=%0d got=%b exp=%b", k, bus.crit_written, k == 0); end
`endif
        end
        @(negedge clk1);
        total++; if (sbq.size() != 0) begin bad++; $display("FAIL crit_left got=%0d exp=0", sbq.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_busy_offer();
        test_reset_mid();
        test_wrap();
        test_crit_order();
        repeat (2) @(negedge clk1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
